// File: rtl/instr_mem_responder.sv
// Instruction memory responder: 1024 x 10-bit program store with a fixed-latency fetch port.
// Program words are loaded through a separate write port. That port only writes while the fetch side is idle.
module instr_mem_responder #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [9:0] addr,
    output logic [9:0] instruction,
    output logic       valid,
    output logic       busy,
    input  logic       load_en,
    input  logic [9:0] load_addr,
    input  logic [9:0] load_data,
    output logic       load_err
);

    // state   | meaning
    // IDLE    | ready for a fetch or a program load
    // WAIT    | fetch accepted, counting down wait states
    // RESP    | instruction presented with valid=1 for this single cycle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic [9:0] addr_q;
    logic [9:0] mem [1024];

    logic accept;
    logic load_ok;
    logic load_drop;

    assign busy      = (state != ST_IDLE) || load_en;
    assign accept    = (state == ST_IDLE) && req && !load_en;
    assign load_ok   = (state == ST_IDLE) && load_en;
    assign load_drop = (state != ST_IDLE) && load_en;
    assign valid     = (state == ST_RESP);

    // The word is captured on entry to RESP. Loads cannot land while a fetch is in flight,
    // so this matches a read of the memory during RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            addr_q      <= 10'd0;
            instruction <= 10'd0;
            load_err    <= 1'b0;
        end else begin
            if (load_drop) begin
                load_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= addr;
                        if (WAIT_CYCLES == 0) begin
                            state       <= ST_RESP;
                            instruction <= mem[addr];
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state       <= ST_RESP;
                        instruction <= mem[addr_q];
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so that loaded programs survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder with three instances (WAIT_CYCLES = 0, 1, 2) on shared stimulus.
// A time-based reference model predicts each response. A negedge monitor checks the outputs every cycle.
module tb_instr_mem_responder;
    localparam int NI = 3;

    typedef struct {
        logic [9:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, req, load_en;
    logic [9:0] addr, load_addr, load_data;
    logic [9:0] instr_w [NI];
    logic       valid_w [NI];
    logic       busy_w  [NI];
    logic       err_w   [NI];

    always #5 clk = ~clk;

    instr_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .instruction(instr_w[0]), .valid(valid_w[0]), .busy(busy_w[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(err_w[0]));
    instr_mem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .instruction(instr_w[1]), .valid(valid_w[1]), .busy(busy_w[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(err_w[1]));
    instr_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req), .addr(addr),
        .instruction(instr_w[2]), .valid(valid_w[2]), .busy(busy_w[2]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_err(err_w[2]));

    // Instance i has WAIT_CYCLES = i. The model records only when each instance is free and what it owes.
    exp_t       exp_q      [NI][$];
    logic [9:0] ref_mem    [NI][1024];
    int         free_at    [NI];
    logic       ref_err    [NI];
    logic [9:0] last_instr [NI];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       model_live = 1'b0;

    task automatic chk(input string name, input int inst, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    // Reference model: a request accepted at edge n returns at the cycle after edge n+W, and the instance is free again from edge n+W+2.
    initial begin
        for (int i = 0; i < NI; i++) begin
            free_at[i]    = 0;
            ref_err[i]    = 1'b0;
            last_instr[i] = 10'd0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    exp_q[i].delete();
                    free_at[i]    = cyc + 1;
                    ref_err[i]    = 1'b0;
                    last_instr[i] = 10'd0;
                end else if (cyc >= free_at[i]) begin
                    if (load_en) begin
                        ref_mem[i][load_addr] = load_data;
                    end else if (req) begin
                        exp_q[i].push_back(exp_t'{ref_mem[i][addr], cyc + i});
                        free_at[i] = cyc + i + 2;
                    end
                end else if (load_en) begin
                    ref_err[i] = 1'b1;
                end
            end
            if (reset) model_live = 1'b1;
        end
    end

    // Monitor
    initial begin
        exp_t e;
        logic exp_v;
        logic exp_busy;
        forever begin
            @(negedge clk);
            if (model_live) begin
                for (int i = 0; i < NI; i++) begin
                    exp_v = (exp_q[i].size() > 0) && (exp_q[i][0].due == cyc);
                    if (exp_v) begin
                        e = exp_q[i].pop_front();
                        last_instr[i] = e.data;
                    end
                    exp_busy = (cyc + 1 < free_at[i]) || load_en;
                    chk("valid", i, {9'd0, valid_w[i]}, {9'd0, exp_v});
                    chk("instruction", i, instr_w[i], last_instr[i]);
                    chk("busy", i, {9'd0, busy_w[i]}, {9'd0, exp_busy});
                    chk("load_err", i, {9'd0, err_w[i]}, {9'd0, ref_err[i]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        req     = 1'b0;
        load_en = 1'b0;
        reset   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic load(input logic [9:0] a, input logic [9:0] d);
        req       = 1'b0;
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] a);
        req  = 1'b1;
        addr = a;
        tick();
        req = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        load_en   = 1'b0;
        addr      = 10'd0;
        load_addr = 10'd0;
        load_data = 10'd0;
        tick();
        tick();
        reset = 1'b0;
        idle(2);

        for (int a = 0; a < 1024; a++) begin
            load(10'(a), 10'($urandom));
        end
        idle(1);

        load(10'd5, 10'h2A7);
        fetch(10'd5);

        load(10'd0, 10'h001);
        load(10'd1023, 10'h3FF);
        req = 1'b1; addr = 10'd1023; tick();
        req = 1'b0; tick();
        req = 1'b1; addr = 10'd0; tick();
        idle(4);

        req = 1'b1; addr = 10'd9;
        load_en = 1'b1; load_addr = 10'd9; load_data = 10'h155;
        tick();
        idle(4);
        fetch(10'd9);

        load(10'd3, 10'h123);
        req = 1'b1; addr = 10'd3; tick();
        req = 1'b0;
        load_en = 1'b1; load_addr = 10'd3; load_data = 10'h0FF; tick();
        idle(4);
        fetch(10'd3);

        req = 1'b1; addr = 10'd5; tick();
        req = 1'b0; reset = 1'b1; tick();
        idle(3);
        fetch(10'd5);

        req = 1'b1;
        for (int k = 0; k < 24; k++) begin
            addr = 10'($urandom);
            tick();
        end
        idle(4);

        for (int k = 0; k < 3000; k++) begin
            req       = 1'($urandom_range(0, 1));
            addr      = 10'($urandom);
            load_en   = ($urandom_range(0, 7) == 0);
            load_addr = 10'($urandom);
            load_data = 10'($urandom);
            reset     = ($urandom_range(0, 127) == 0);
            tick();
        end
        idle(6);

        for (int i = 0; i < NI; i++) begin
            chk("drained", i, 10'(exp_q[i].size()), 10'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
